multicycle_control: RTL and testbench

Control unit for the multi-cycle RV32I-subset datapath. It sequences every instruction through fetch, decode, execute, memory and writeback states, and generates all datapath enables and mux selects. It drives the ALU's `sel`/`Cin` inputs and consumes its `Zero` flag. The block sits directly upstream of the ALU and is its only source of operation control.

---
 rtl/riscv_ctrl_pkg.sv | 55 +++++
 rtl/alu_decoder.sv | 44 ++++
 rtl/multicycle_control.sv | 173 +++++++++++++++++
 tb/tb_multicycle_control.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset control unit:
// FSM states, supported opcodes, ALU select codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALU select encodings
  localparam logic [1:0] ALU_SEL_ADD_SUB = 2'b00;
  localparam logic [1:0] ALU_SEL_SLT     = 2'b01;
  localparam logic [1:0] ALU_SEL_OR      = 2'b10;
  localparam logic [1:0] ALU_SEL_AND     = 2'b11;

  // Operation class handed from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Mux selects
  localparam logic       ADR_PC      = 1'b0;
  localparam logic       ADR_ALUOUT  = 1'b1;
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALU     = 2'b10;
  localparam logic [1:0] SRCA_PC     = 2'b00;
  localparam logic [1:0] SRCA_OLDPC  = 2'b01;
  localparam logic [1:0] SRCA_RS1    = 2'b10;
  localparam logic [1:0] SRCB_RS2    = 2'b00;
  localparam logic [1:0] SRCB_IMM    = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_JAL) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode: turns the FSM's operation class plus the
// instruction function fields into the ALU select and carry-in.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [1:0] alu_sel,
  output logic       alu_cin,
  output logic       bad_funct
);

  // bad_funct flags an unsupported funct3 independent of alu_op so the FSM
  // can raise it in DECODE, before the execute state is reached.
  always_comb begin
    alu_sel   = ALU_SEL_ADD_SUB;
    alu_cin   = 1'b0;
    bad_funct = 1'b0;
    case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: bad_funct = 1'b0;
      default:                        bad_funct = 1'b1;
    endcase
    case (alu_op)
      ALUOP_SUB: alu_cin = 1'b1;
      ALUOP_FUNCT: begin
        case (funct3)
          // op5 separates R-type (sub allowed) from I-type addi
          3'b000: alu_cin = op5 & funct7b5;
          3'b010: begin
            alu_sel = ALU_SEL_SLT;
            alu_cin = 1'b1;
          end
          3'b110:  alu_sel = ALU_SEL_OR;
          3'b111:  alu_sel = ALU_SEL_AND;
          default: alu_sel = ALU_SEL_ADD_SUB;
        endcase
      end
      default: alu_cin = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for the multi-cycle RV32I-subset datapath.
//
// state    | meaning
// FETCH    | read instruction, PC <= PC+4
// DECODE   | read registers, compute branch target
// MEMADR   | rs1 + imm address for lw/sw
// MEMREAD  | read data memory
// MEMWB    | write loaded data to rd
// MEMWRITE | write rs2 to data memory
// EXECR    | R-type ALU operation
// EXECI    | I-type ALU operation
// ALUWB    | write ALUOut to rd
// JAL      | PC <= target, compute return address
// BEQ      | compare rs1/rs2, branch on zero
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_write,
  output logic [1:0]         alu_sel,
  output logic               alu_cin,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_e     state_q, state_d;
  logic       pc_write_c, adr_src_c, mem_write_c, ir_write_c, reg_write_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
  logic       illegal_c;
  logic [1:0] alu_sel_c;
  logic       alu_cin_c, bad_funct;
  logic       is_ri;

  assign is_ri = (op == OP_RTYPE) || (op == OP_ITYPE);

  // Next-state selection; unknown encodings fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Per-state datapath controls
  always_comb begin
    pc_write_c   = 1'b0;
    adr_src_c    = ADR_PC;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    result_src_c = RES_ALUOUT;
    alu_src_a_c  = SRCA_PC;
    alu_src_b_c  = SRCB_RS2;
    alu_op_c     = ALUOP_ADD;
    illegal_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c   = 1'b1;
        pc_write_c   = 1'b1;
        alu_src_b_c  = SRCB_FOUR;
        result_src_c = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_IMM;
        illegal_c   = !op_supported(op) || (is_ri && bad_funct);
      end
      S_MEMADR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
      end
      S_MEMREAD: adr_src_c = ADR_ALUOUT;
      S_MEMWB: begin
        result_src_c = RES_MEMDATA;
        reg_write_c  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src_c   = ADR_ALUOUT;
        mem_write_c = 1'b1;
      end
      S_EXECR: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_RS2;
        alu_op_c    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a_c = SRCA_RS1;
        alu_src_b_c = SRCB_IMM;
        alu_op_c    = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_JAL: begin
        alu_src_a_c = SRCA_OLDPC;
        alu_src_b_c = SRCB_FOUR;
        pc_write_c  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a_c  = SRCA_RS1;
        alu_src_b_c  = SRCB_RS2;
        alu_op_c     = ALUOP_SUB;
        result_src_c = RES_ALUOUT;
        pc_write_c   = zero;
      end
      default: pc_write_c = 1'b0;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op    (alu_op_c),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .op5       (op[5]),
    .alu_sel   (alu_sel_c),
    .alu_cin   (alu_cin_c),
    .bad_funct (bad_funct)
  );

  // Reset gating: the FETCH decode would otherwise raise pc_write/ir_write
  // while rst_n is low, so enables are ANDed with rst_n and cannot glitch.
  assign pc_write   = rst_n & pc_write_c;
  assign adr_src    = rst_n & adr_src_c;
  assign mem_write  = rst_n & mem_write_c;
  assign ir_write   = rst_n & ir_write_c;
  assign reg_write  = rst_n & reg_write_c;
  assign illegal    = rst_n & illegal_c;
  assign alu_cin    = rst_n & alu_cin_c;
  assign alu_sel    = rst_n ? alu_sel_c : ALU_SEL_ADD_SUB;
  assign alu_src_a  = rst_n ? alu_src_a_c : SRCA_PC;
  assign alu_src_b  = rst_n ? alu_src_b_c : SRCB_FOUR;
  assign result_src = rst_n ? result_src_c : RES_ALU;
  assign state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control with an
// instruction-level reference model (state path per class, outputs per step).
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_sel;
  logic       alu_cin, illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

  multicycle_control #(.STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .reg_write(reg_write), .alu_sel(alu_sel),
    .alu_cin(alu_cin), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  wire [14:0] out_vec = {pc_write, adr_src, mem_write, ir_write, result_src,
                         alu_src_a, alu_src_b, reg_write, alu_sel, alu_cin, illegal};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [14:0] pack(logic pcw, logic adr, logic mw, logic irw,
                                       logic [1:0] rs, logic [1:0] sa, logic [1:0] sb,
                                       logic rw, logic [1:0] sel, logic cin, logic ill);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, sel, cin, ill};
  endfunction

  function automatic bit known_op(logic [6:0] o);
    return o == LW || o == SW || o == RT || o == IT || o == JL || o == BQ;
  endfunction

  function automatic bit known_f3(logic [2:0] f);
    return f == 3'd0 || f == 3'd2 || f == 3'd6 || f == 3'd7;
  endfunction

  // Expected control word for one step of an instruction (step named by
  // the architectural state number from the state table).
  function automatic logic [14:0] exp_out(int st, logic [6:0] o, logic [2:0] f3,
                                          logic f7, logic z);
    logic pcw, adr, mw, irw, rw, cin, ill;
    logic [1:0] rs, sa, sb, sel;
    bit fdec;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; cin = 0; ill = 0;
    rs = 0; sa = 0; sb = 0; sel = 0; fdec = 0;
    case (st)
      0:  begin irw = 1; pcw = 1; sb = 2; rs = 2; end
      1:  begin sa = 1; sb = 1;
                ill = !known_op(o) || ((o == RT || o == IT) && !known_f3(f3)); end
      2:  begin sa = 2; sb = 1; end
      3:  adr = 1;
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin sa = 2; fdec = 1; end
      7:  begin sa = 2; sb = 1; fdec = 1; end
      8:  rw = 1;
      9:  begin sa = 1; sb = 2; pcw = 1; end
      10: begin sa = 2; cin = 1; pcw = z; end
      default: ;
    endcase
    if (fdec) begin
      case (f3)
        3'd0: cin = (o == RT) && f7;
        3'd2: begin sel = 1; cin = 1; end
        3'd6: sel = 2;
        3'd7: sel = 3;
        default: ;
      endcase
    end
    return pack(pcw, adr, mw, irw, rs, sa, sb, rw, sel, cin, ill);
  endfunction

  // Called just after a negedge while the DUT sits in FETCH.
  task automatic run_instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z);
    int seq[$];
    case (o)
      LW:      seq = '{0, 1, 2, 3, 4};
      SW:      seq = '{0, 1, 2, 5};
      RT:      seq = '{0, 1, 6, 8};
      IT:      seq = '{0, 1, 7, 8};
      JL:      seq = '{0, 1, 9, 8};
      BQ:      seq = '{0, 1, 10};
      default: seq = '{0, 1};
    endcase
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    foreach (seq[i]) begin
      #1;
      chk($sformatf("%s st%0d state", name, i), 32'(state), 32'(seq[i]));
      chk($sformatf("%s st%0d outs", name, i), 32'(out_vec),
          32'(exp_out(seq[i], o, f3, f7, z)));
      @(negedge clk);
    end
  endtask

  logic [14:0] rst_vec;
  logic [6:0]  rop;

  initial begin
    rst_vec = pack(0, 0, 0, 0, 2'd2, 2'd0, 2'd2, 0, 2'd0, 0, 0);
    rst_n = 1'b0; op = RT; funct3 = 0; funct7b5 = 0; zero = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset state", 32'(state), 0);
    chk("reset outs", 32'(out_vec), 32'(rst_vec));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("lw", LW, 3'd2, 0, 0);
    run_instr("sw", SW, 3'd2, 0, 1);
    run_instr("sub", RT, 3'd0, 1, 0);
    run_instr("add", RT, 3'd0, 0, 0);
    run_instr("slt", RT, 3'd2, 0, 0);
    run_instr("or", RT, 3'd6, 0, 0);
    run_instr("and", RT, 3'd7, 1, 0);
    run_instr("addi", IT, 3'd0, 1, 0);
    run_instr("ori", IT, 3'd6, 0, 1);
    run_instr("rbadf3", RT, 3'd1, 0, 0);
    run_instr("beq_t", BQ, 3'd0, 0, 1);
    run_instr("beq_nt", BQ, 3'd0, 0, 0);
    run_instr("jal", JL, 3'd5, 0, 0);
    run_instr("illegal", 7'b1111111, 3'd0, 0, 0);

    // Reset held for three cycles in the middle of an R-type execute
    op = RT; funct3 = 3'd0; funct7b5 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre-reset execr state", 32'(state), 6);
    chk("pre-reset execr outs", 32'(out_vec), 32'(exp_out(6, RT, 3'd0, 1, 0)));
    rst_n = 1'b0;
    #1;
    chk("mid reset state", 32'(state), 0);
    chk("mid reset outs", 32'(out_vec), 32'(rst_vec));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("held reset c%0d state", c), 32'(state), 0);
      chk($sformatf("held reset c%0d outs", c), 32'(out_vec), 32'(rst_vec));
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("post-reset lw", LW, 3'd2, 0, 0);

    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(6))
        0: rop = LW;
        1: rop = SW;
        2: rop = RT;
        3: rop = IT;
        4: rop = JL;
        5: rop = BQ;
        default: begin
          rop = 7'($urandom);
          while (known_op(rop)) rop = 7'($urandom);
        end
      endcase
      run_instr($sformatf("rnd%0d", k), rop, 3'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
